// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the single-cycle MIPS core, with a
// valid/ready program loader. Define LOAD_CHECKSUM_EN to add the ld_checksum output.
module mips_mem_responder #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic [31:0] d_rdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        ld_trunc,
`ifdef LOAD_CHECKSUM_EN
  output logic [31:0] ld_checksum,
`endif
  output logic        addr_err
);

  localparam int IMEM_DEPTH = 1 << IMEM_AW;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;
  localparam logic [IMEM_AW-1:0] LD_PTR_MAX = '1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ld_ptr_q, ld_ptr_d;
  logic               ld_trunc_q, ld_trunc_d;
  logic               addr_err_q, addr_err_d;
  logic               cpu_rst_n_q;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic               imem_we;
  logic               dmem_we;
  logic               run;
  logic               d_in_range;
  logic [IMEM_AW-1:0] i_word;
  logic [DMEM_AW-1:0] d_word;

  // Upper pc bits are deliberately ignored: the image is mirrored across the space.
  logic [31-IMEM_AW-2:0] unused_pc_hi;
  assign unused_pc_hi = pc[31:IMEM_AW+2];

  assign run        = (state_q == S_RUN);
  assign i_word     = pc[IMEM_AW+1:2];
  assign d_word     = d_addr[DMEM_AW+1:2];
  assign d_in_range = (d_addr[31:DMEM_AW+2] == '0) && (d_addr[1:0] == 2'b00);

  // NOTE: every variable assigned in this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    ld_trunc_d = ld_trunc_q;
    addr_err_d = addr_err_q;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (ld_valid) begin
          imem_we  = 1'b1;
          ld_ptr_d = (ld_ptr_q == LD_PTR_MAX) ? ld_ptr_q : ld_ptr_q + IMEM_AW'(1);
          if (ld_last) begin
            state_d = S_SETTLE;
          end else if (ld_ptr_q == LD_PTR_MAX) begin
            state_d    = S_SETTLE;
            ld_trunc_d = 1'b1;
          end
        end
      end
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (pc[1:0] != 2'b00) addr_err_d = 1'b1;
        if (d_we) begin
          if (d_in_range) dmem_we = 1'b1;
          else            addr_err_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      ld_ptr_q    <= '0;
      ld_trunc_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_trunc_q  <= ld_trunc_d;
      addr_err_q  <= addr_err_d;
      cpu_rst_n_q <= run;
    end
  end

  // NOTE: the arrays have no reset; contents survive rst so a reload only rewrites imem.
  always_ff @(posedge clk) begin
    if (imem_we) imem[ld_ptr_q] <= ld_data;
    if (dmem_we) dmem[d_word]   <= d_wdata;
  end

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] ld_checksum_q;

  always_ff @(posedge clk) begin
    if (rst)          ld_checksum_q <= '0;
    else if (imem_we) ld_checksum_q <= ld_checksum_q + ld_data;
  end

  assign ld_checksum = ld_checksum_q;
`endif

  // Reads are asynchronous, so a same-word store is visible only after its edge.
  assign instr     = run ? imem[i_word] : '0;
  assign d_rdata   = d_in_range ? dmem[d_word] : '0;
  assign ld_ready  = (state_q == S_LOAD);
  assign load_done = run;
  assign cpu_rst_n = cpu_rst_n_q;
  assign ld_trunc  = ld_trunc_q;
  assign addr_err  = addr_err_q;

endmodule
